// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I IF stage: PC generation, imem fetch, IF/ID register
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_valid
);

  // ISSUE: request goes out this cycle; WAIT: live request outstanding;
  // HOLD: response parked while decode is stalled; DRAIN: stale request outstanding.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        vld_q, vld_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        req_outstanding;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A request is in flight after this edge if one is already waiting, or if
  // ISSUE is putting one on the bus right now.
  assign req_outstanding = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);

  // Next-state, request strobe and IF/ID update; redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ifpc_d    = ifpc_q;
    vld_d     = vld_q;
    hold_ir_d = hold_ir_q;
    hold_pc_d = hold_pc_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    // Any non-stalled cycle that does not deliver an instruction is a bubble.
    if (!stall) begin
      ir_d  = NOP_INSTR;
      vld_d = 1'b0;
    end

    case (state_q)
      S_ISSUE: begin
        imem_req = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (!stall) begin
            ir_d      = imem_rdata;
            ifpc_d    = pc_q;
            vld_d     = 1'b1;
            pc_d      = pc_plus4;
            imem_req  = 1'b1;
            imem_addr = pc_plus4;
          end else begin
            hold_ir_d = imem_rdata;
            hold_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ir_d    = hold_ir_q;
          ifpc_d  = hold_pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (imem_valid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    if (redirect_en) begin
      ir_d      = NOP_INSTR;
      ifpc_d    = 32'd0;
      vld_d     = 1'b0;
      pc_d      = redirect_target;
      hold_ir_d = 32'd0;
      hold_pc_d = 32'd0;
      // Only ISSUE keeps its strobe; the WAIT back-to-back request is cancelled.
      imem_req  = (state_q == S_ISSUE);
      imem_addr = pc_q;
      if (req_outstanding && !(imem_valid && (state_q != S_ISSUE))) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_ISSUE;
      end
    end

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // State, PC, IF/ID and hold-buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ISSUE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      ifpc_q    <= 32'd0;
      vld_q     <= 1'b0;
      hold_ir_q <= 32'd0;
      hold_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ifpc_q    <= ifpc_d;
      vld_q     <= vld_d;
      hold_ir_q <= hold_ir_d;
      hold_pc_q <= hold_pc_d;
    end
  end

  assign IF_ID_IR    = ir_q;
  assign IF_ID_PC    = ifpc_q;
  assign IF_ID_valid = vld_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized model-checked bench for instruction_fetch
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_valid = 1'b0;
  logic [31:0] IF_ID_IR;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_valid;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .IF_ID_IR(IF_ID_IR), .IF_ID_PC(IF_ID_PC), .IF_ID_valid(IF_ID_valid)
  );

  int checks = 0;
  int errors = 0;

  // Memory: one request in flight, latency fixed or random 1..3.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  int          lat_cfg = 1;

  // Reference: next fetch address, in-flight request (and whether it is stale),
  // parked response, and the IF/ID contents.
  logic [31:0] m_pc = 32'd0, m_ir = NOP, m_ifpc = 32'd0, m_hir = 32'd0, m_hpc = 32'd0;
  bit          m_out = 0, m_stale = 0, m_hold = 0, m_vld = 0;

  bit          last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit re, input logic [31:0] rp);
    bit          m_req, b2b, got, loaded;
    logic [31:0] m_addr;
    @(negedge clk);
    rst = r; stall = s; redirect_en = re; redirect_pc = rp;
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = tag(mem_addr);
        mem_pend   = 0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
    b2b    = m_out && !m_stale && imem_valid && !s && !re;
    m_req  = !r && ((!m_out && !m_hold) || b2b);
    m_addr = b2b ? m_pc + 32'd4 : m_pc;
    last_req  = imem_req;
    last_addr = imem_addr;
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    if (imem_req) begin
      mem_pend = 1;
      mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
      mem_addr = imem_addr;
    end
    if (r) begin
      m_pc = 32'd0; m_out = 0; m_stale = 0; m_hold = 0;
      m_ir = NOP; m_ifpc = 32'd0; m_vld = 0;
    end else begin
      got = m_out && imem_valid;
      if (re) begin
        m_out   = m_req || (m_out && !imem_valid);
        m_stale = m_out;
        m_hold  = 0;
        m_ir = NOP; m_ifpc = 32'd0; m_vld = 0;
        m_pc = {rp[31:2], 2'b00};
      end else begin
        loaded = 0;
        if (got && !m_stale) begin
          if (!s) begin
            m_ir = imem_rdata; m_ifpc = m_pc; m_vld = 1; m_pc = m_pc + 32'd4; loaded = 1;
          end else begin
            m_hold = 1; m_hir = imem_rdata; m_hpc = m_pc;
          end
        end else if (m_hold && !s) begin
          m_ir = m_hir; m_ifpc = m_hpc; m_vld = 1; m_pc = m_pc + 32'd4; m_hold = 0; loaded = 1;
        end
        if (got) m_out = 0;
        if (m_req) begin m_out = 1; m_stale = 0; end
        if (!s && !loaded) begin m_ir = NOP; m_vld = 0; end
      end
    end
    @(posedge clk);
    #1;
    chk("IF_ID_IR", IF_ID_IR, m_ir);
    chk("IF_ID_PC", IF_ID_PC, m_ifpc);
    chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_vld));
    if (IF_ID_valid) chk("ir_matches_pc", IF_ID_IR, tag(IF_ID_PC));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit found;

    // Reset values and 1-cycle streaming.
    lat_cfg = 1;
    do_reset();
    chk("rst_ir", IF_ID_IR, NOP);
    chk("rst_pc", IF_ID_PC, 32'd0);
    chk("rst_vld", 32'(IF_ID_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 32'd0);
      chk("seq_req", 32'(last_req), 32'd1);
      chk("seq_addr", last_addr, 32'(4 * k));
      if (k > 0) begin
        chk("seq_pc", IF_ID_PC, 32'(4 * (k - 1)));
        chk("seq_vld", 32'(IF_ID_valid), 32'd1);
      end
    end

    // 3-cycle latency: valid pattern 1,0,0.
    lat_cfg = 3;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 32'd0);
      if (i >= 3) begin
        chk("lat3_vld", 32'(IF_ID_valid), ((i - 3) % 3 == 0) ? 32'd1 : 32'd0);
        if ((i - 3) % 3 != 0) chk("lat3_bubble", IF_ID_IR, NOP);
      end
    end

    // Stall for two cycles while the PC 8 response arrives.
    lat_cfg = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'd0);
    step(0, 1, 0, 32'd0);
    chk("stall1_req", 32'(last_req), 32'd0);
    chk("stall1_pc", IF_ID_PC, 32'd4);
    step(0, 1, 0, 32'd0);
    chk("stall2_req", 32'(last_req), 32'd0);
    chk("stall2_pc", IF_ID_PC, 32'd4);
    step(0, 0, 0, 32'd0);
    chk("unstall_pc", IF_ID_PC, 32'd8);
    chk("unstall_ir", IF_ID_IR, tag(32'd8));
    chk("unstall_vld", 32'(IF_ID_valid), 32'd1);
    step(0, 0, 0, 32'd0);
    chk("after_hold_req", 32'(last_req), 32'd1);
    chk("after_hold_addr", last_addr, 32'd12);
    step(0, 0, 0, 32'd0);
    chk("after_hold_pc", IF_ID_PC, 32'd12);

    // Redirect while the 0x10 request is outstanding.
    lat_cfg = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 0, 32'd0);
      if (last_req && last_addr == 32'h10) found = 1;
    end
    chk("find_req_0x10", 32'(found), 32'd1);
    step(0, 0, 1, 32'h0000_0103);
    chk("redir_flush_vld", 32'(IF_ID_valid), 32'd0);
    chk("redir_flush_ir", IF_ID_IR, NOP);
    chk("redir_flush_pc", IF_ID_PC, 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 0, 32'd0);
      if (last_req) found = 1;
      else chk("drain_vld", 32'(IF_ID_valid), 32'd0);
    end
    chk("redir_req_seen", 32'(found), 32'd1);
    chk("redir_addr", last_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(0, 0, 0, 32'd0);
      if (IF_ID_valid) found = 1;
    end
    chk("redir_target_vld", 32'(found), 32'd1);
    chk("redir_target_pc", IF_ID_PC, 32'h100);
    chk("redir_target_ir", IF_ID_IR, tag(32'h100));

    // Redirect coincident with a response under stall.
    lat_cfg = 1;
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 1, 1, 32'h40);
    chk("coinc_req", 32'(last_req), 32'd0);
    chk("coinc_vld", 32'(IF_ID_valid), 32'd0);
    chk("coinc_ir", IF_ID_IR, NOP);
    step(0, 0, 0, 32'd0);
    chk("coinc_next_req", 32'(last_req), 32'd1);
    chk("coinc_next_addr", last_addr, 32'h40);
    step(0, 0, 0, 32'd0);
    chk("coinc_target_pc", IF_ID_PC, 32'h40);
    chk("coinc_target_vld", 32'(IF_ID_valid), 32'd1);

    // Reset while waiting; the late response lands during reset.
    lat_cfg = 3;
    do_reset();
    step(0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 32'd0);
      chk("midrst_req", 32'(last_req), 32'd0);
      chk("midrst_vld", 32'(IF_ID_valid), 32'd0);
      chk("midrst_ir", IF_ID_IR, NOP);
    end
    step(0, 0, 0, 32'd0);
    chk("postrst_req", 32'(last_req), 32'd1);
    chk("postrst_addr", last_addr, 32'd0);

    // PC wrap past 0xFFFFFFFC.
    lat_cfg = 1;
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'd0);
    chk("wrap_addr0", last_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'd0);
    chk("wrap_req", 32'(last_req), 32'd1);
    chk("wrap_addr1", last_addr, 32'd0);
    chk("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);

    // Random traffic against the reference.
    lat_cfg = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
